// File: rtl/instr_dispatch.sv
//------------------------------------------------------------------------------
// Module      : instr_dispatch
// Description : Pops 80-bit instructions from the instruction FIFO, decodes the
//               opcode and hands each one to the weight, matmul or activation
//               unit over valid/ready; executes NOP, SYNC and HALT itself.
//               Optional retired-instruction counter: INSTR_DISPATCH_RETIRE_COUNT_EN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_dispatch #(
  parameter int INSTR_WIDTH = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_next_en,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   weight_valid,
  output logic                   matmul_valid,
  output logic                   act_valid,
  input  logic                   weight_ready,
  input  logic                   matmul_ready,
  input  logic                   act_ready,
  input  logic                   weight_busy,
  input  logic                   matmul_busy,
  input  logic                   act_busy,
  output logic                   sync_wait,
  output logic                   halted,
  output logic                   illegal_instr
`ifdef INSTR_DISPATCH_RETIRE_COUNT_EN
  ,
  output logic [31:0]            retired_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_SYNC     = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_SYNC    = 3'd1,
    CLS_HALT    = 3'd2,
    CLS_WEIGHT  = 3'd3,
    CLS_MATMUL  = 3'd4,
    CLS_ACT     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_e;

  function automatic cls_e decode(input logic [7:0] op);
    cls_e c;
    c = CLS_ILLEGAL;
    if (op == 8'h00) begin
      c = CLS_NOP;
    end else if (op == 8'h01) begin
      c = CLS_SYNC;
    end else if (op == 8'hFF) begin
      c = CLS_HALT;
    end else begin
      case (op[7:5])
        3'b001:  c = CLS_WEIGHT;
        3'b010:  c = CLS_MATMUL;
        3'b100:  c = CLS_ACT;
        default: c = CLS_ILLEGAL;
      endcase
    end
    return c;
  endfunction

  state_e                 state_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   weight_valid_q;
  logic                   matmul_valid_q;
  logic                   act_valid_q;
  logic                   illegal_q;
  logic                   halted_q;

  cls_e   cur_cls;
  cls_e   new_cls;
  state_e load_state;
  logic   accept;
  logic   disp_done;
  logic   any_busy;
  logic   pop;

  always_comb begin
    cur_cls    = decode(instr_q[7:0]);
    new_cls    = decode(fifo_data[7:0]);
    accept     = (weight_valid_q & weight_ready) |
                 (matmul_valid_q & matmul_ready) |
                 (act_valid_q    & act_ready);
    disp_done  = accept || (cur_cls == CLS_NOP) || (cur_cls == CLS_ILLEGAL);
    any_busy   = weight_busy | matmul_busy | act_busy;
    // A latched SYNC goes straight to the wait state so sync_wait rises one cycle after the pop.
    load_state = (new_cls == CLS_SYNC) ? ST_SYNC : ST_DISPATCH;
    pop        = 1'b0;
    if (!rst && !fifo_empty) begin
      if (state_q == ST_IDLE) begin
        pop = 1'b1;
      end else if (state_q == ST_DISPATCH && disp_done) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      instr_q        <= '0;
      weight_valid_q <= 1'b0;
      matmul_valid_q <= 1'b0;
      act_valid_q    <= 1'b0;
      illegal_q      <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        ST_DISPATCH: begin
          if (cur_cls == CLS_HALT) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (cur_cls == CLS_SYNC) begin
            state_q <= ST_SYNC;
          end else if (disp_done) begin
            weight_valid_q <= 1'b0;
            matmul_valid_q <= 1'b0;
            act_valid_q    <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (!any_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
        end
      endcase
      // Refill overrides the retire path above when the FIFO has another entry.
      if (pop) begin
        instr_q        <= fifo_data;
        state_q        <= load_state;
        weight_valid_q <= (new_cls == CLS_WEIGHT);
        matmul_valid_q <= (new_cls == CLS_MATMUL);
        act_valid_q    <= (new_cls == CLS_ACT);
        illegal_q      <= (new_cls == CLS_ILLEGAL);
      end
    end
  end

  // Strobes are masked during reset so a dropped handshake never leaks out.
  assign fifo_next_en  = pop;
  assign instr_out     = instr_q;
  assign weight_valid  = weight_valid_q & ~rst;
  assign matmul_valid  = matmul_valid_q & ~rst;
  assign act_valid     = act_valid_q    & ~rst;
  assign illegal_instr = illegal_q      & ~rst;
  assign sync_wait     = (state_q == ST_SYNC);
  assign halted        = halted_q;

`ifdef INSTR_DISPATCH_RETIRE_COUNT_EN
  logic        retire;
  logic [31:0] retired_count_q;

  always_comb begin
    retire = 1'b0;
    if (state_q == ST_DISPATCH) begin
      retire = accept || (cur_cls == CLS_NOP) || (cur_cls == CLS_HALT);
    end else if (state_q == ST_SYNC) begin
      retire = !any_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count_q <= '0;
    end else if (retire) begin
      retired_count_q <= retired_count_q + 32'd1;
    end
  end

  assign retired_count = retired_count_q;
`endif

endmodule

`default_nettype wire
